// File: rtl/html_pkg.sv
// Shared types and constants for the HTML character stream path.
// Character width, special characters and controller state encoding.
package html_pkg;

  localparam int CHAR_BITES = 8;

  localparam logic [CHAR_BITES-1:0] CHAR_NUL = 8'h00;
  localparam logic [CHAR_BITES-1:0] CHAR_LF  = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/html_stream_controller_char_fifo.sv
// char_fifo: DEPTH x CHAR_BITES sync FIFO, push/pop/clear, occupancy count.
// Ports: clk_i, rst_ni, push_i/data_i, pop_i, clear_i, data_o (head), count_o, empty_o.
import html_pkg::*;

module char_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic [CHAR_BITES-1:0]   data_i,
  input  logic                    pop_i,
  input  logic                    clear_i,
  output logic [CHAR_BITES-1:0]   data_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [CHAR_BITES-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_q, wr_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [AW:0]           cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      unique case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/html_stream_controller.sv
// Reader-to-tokenizer sequencer: one-request credit fetch, FIFO, line/col tags.
// Ports: clock/state_enable, start/abort, src_* reader side, out_* stream side, busy/done.
import html_pkg::*;

module html_stream_controller #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 16,
  parameter int COL_W  = 12
) (
  input  logic                  clock,
  input  logic                  state_enable,
  input  logic                  start,
  input  logic                  abort,
  output logic                  src_req,
  input  logic                  src_valid,
  input  logic                  src_eof,
  input  logic [CHAR_BITES-1:0] src_char,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CHAR_BITES-1:0] out_char,
  output logic                  out_last,
  output logic [LINE_W-1:0]     out_line,
  output logic [COL_W-1:0]      out_col,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e              state_q, state_d;
  logic                infl_q, infl_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [COL_W-1:0]    col_q, col_d;

  logic [CW-1:0]         count;
  logic                  empty;
  logic [CHAR_BITES-1:0] head;

  logic live, abort_ok, resp, push, pop, term, has_char;

  assign live     = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign abort_ok = abort && live;
  assign resp     = infl_q && (src_valid || src_eof);
  assign has_char = live && !empty;
  assign term     = (state_q == ST_DRAIN) && empty;

  // Only one credit: a request also reserves the FIFO slot it will fill.
  assign src_req  = (state_q == ST_FETCH) && !infl_q
                 && (count < CW'(DEPTH)) && !abort;
  assign push     = infl_q && src_valid
                 && (state_q == ST_FETCH) && !abort_ok;

  assign out_valid = has_char || term;
  assign out_last  = term;
  assign out_char  = has_char ? head : CHAR_NUL;
  assign out_line  = line_q;
  assign out_col   = col_q;
  assign pop       = has_char && out_ready;

  assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done = (state_q == ST_DONE);

  char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clock),
    .rst_ni  (state_enable),
    .push_i  (push),
    .data_i  (src_char),
    .pop_i   (pop),
    .clear_i (abort_ok),
    .data_o  (head),
    .count_o (count),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    infl_d  = infl_q;
    line_d  = line_q;
    col_d   = col_q;

    if (src_req)   infl_d = 1'b1;
    else if (resp) infl_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          line_d  = LINE_W'(1);
          col_d   = COL_W'(1);
        end
      end
      ST_FETCH: begin
        if (abort)                 state_d = ST_FLUSH;
        else if (src_eof && infl_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)                  state_d = ST_FLUSH;
        else if (term && out_ready) state_d = ST_DONE;
      end
      ST_FLUSH: begin
        if (!infl_q || resp) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      unique case (1'b1)
        (head == CHAR_LF): begin
          if (line_q != '1) line_d = line_q + LINE_W'(1);
          col_d = COL_W'(1);
        end
        default: begin
          if (col_q != '1) col_d = col_q + COL_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge state_enable) begin
    if (!state_enable) begin
      state_q <= ST_IDLE;
      infl_q  <= 1'b0;
      line_q  <= LINE_W'(1);
      col_q   <= COL_W'(1);
    end else begin
      state_q <= state_d;
      infl_q  <= infl_d;
      line_q  <= line_d;
      col_q   <= col_d;
    end
  end

endmodule

// File: tb/tb_html_stream_controller.sv
// Randomized bench: reader model with latency, random back-pressure, beat scoreboard.
// Expected beats come from the file contents and the line/column rules.
module tb_html_stream_controller;

  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0]  c;
    logic        last;
    logic [15:0] ln;
    logic [11:0] cl;
  } beat_t;

  logic        clock = 1'b0;
  logic        state_enable;
  logic        start, abort;
  logic        src_req, src_valid, src_eof;
  logic [7:0]  src_char;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_char;
  logic [15:0] out_line;
  logic [11:0] out_col;
  logic        busy, done;

  html_stream_controller #(
    .DEPTH(DEPTH), .LINE_W(16), .COL_W(12)
  ) dut (
    .clock(clock), .state_enable(state_enable),
    .start(start), .abort(abort),
    .src_req(src_req), .src_valid(src_valid),
    .src_eof(src_eof), .src_char(src_char),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_char(out_char), .out_last(out_last),
    .out_line(out_line), .out_col(out_col),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] file_q[$];
  beat_t      exp_q[$];
  int rd_idx, lat_g, wcnt, ready_mode;
  int n_push, n_acc, held_now;
  bit outst, aborted, start_req, abort_req;
  bit prv, pre, pv, pr, pa;
  logic [37:0] pbeat;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic check_rst(input string tag);
    chk(tag, {src_req, out_valid, out_last, out_char,
              out_line, out_col, busy, done},
        {3'b000, 8'h00, 16'd1, 12'd1, 2'b00});
  endtask

  function automatic logic [7:0] rchar(input bit lf_ok);
    if (lf_ok && $urandom_range(0, 5) == 0) return 8'h0A;
    return 8'($urandom_range(32, 126));
  endfunction

  task automatic gen_file(input int n);
    file_q.delete();
    for (int i = 0; i < n; i++) file_q.push_back(rchar(1'b1));
  endtask

  function automatic void build_exp();
    int ln = 1;
    int cl = 1;
    exp_q.delete();
    foreach (file_q[i]) begin
      exp_q.push_back('{file_q[i], 1'b0, 16'(ln), 12'(cl)});
      if (file_q[i] == 8'h0A) begin
        ln = (ln == 65535) ? ln : ln + 1;
        cl = 1;
      end else begin
        cl = (cl == 4095) ? cl : cl + 1;
      end
    end
    exp_q.push_back('{8'h00, 1'b1, 16'(ln), 12'(cl)});
  endfunction

  task automatic clear_bench();
    wcnt = 0; outst = 0; prv = 0; pre = 0; pv = 0; pr = 0; pa = 0;
    n_push = 0; n_acc = 0; rd_idx = 0; aborted = 0;
    start_req = 0; abort_req = 0;
  endtask

  task automatic tick();
    bit rv, re;
    beat_t e;
    @(posedge clock); #1;
    rv = 0; re = 0;
    src_valid = 0; src_eof = 0; src_char = '0;
    if (wcnt > 0) begin
      wcnt--;
      if (wcnt == 0) begin
        if (rd_idx < file_q.size()) begin
          src_valid = 1; src_char = file_q[rd_idx];
          rd_idx++; rv = 1;
        end else begin
          src_eof = 1; re = 1;
        end
      end
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
    start = start_req; start_req = 0;
    abort = abort_req; abort_req = 0;
    if (abort) begin
      aborted = 1;
      exp_q.delete();
    end
    @(negedge clock);
    held_now = n_push - n_acc;
    if (src_req) chk("one_req", outst, 0);
    if (rv || re) outst = 0;
    if (src_req) begin
      outst = 1;
      wcnt = lat_g;
    end
    if (prv && !aborted) chk("fill_lat", out_valid, 1);
    if (pre && !aborted && held_now == 0)
      chk("eof_term", {out_valid, out_last, out_char}, {2'b11, 8'h00});
    if (!aborted && busy && held_now >= DEPTH)
      chk("full_noreq", src_req, 0);
    if (pv && !pr && !pa)
      chk("hold", {out_valid, out_last, out_char, out_line, out_col},
          {1'b1, pbeat[36:0]});
    if (aborted) begin
      if (!abort) chk("abort_quiet", out_valid, 0);
    end else if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {out_char, out_last, out_line, out_col},
            {e.c, e.last, e.ln, e.cl});
        if (!e.last) n_acc++;
      end
    end
    if (rv) n_push++;
    prv = rv; pre = re;
    pv = out_valid; pr = out_ready; pa = abort;
    pbeat = {1'b0, out_last, out_char, out_line, out_col};
  endtask

  task automatic do_reset();
    @(negedge clock); #2;
    state_enable = 0;
    #1 check_rst("rst_async");
    clear_bench();
    src_valid = 0; src_eof = 0; src_char = '0;
    start = 0; abort = 0; out_ready = 0;
    @(posedge clock); #1 check_rst("rst_hold");
    @(negedge clock); #2 state_enable = 1;
  endtask

  task automatic start_stream(input int lat, input int mode);
    clear_bench();
    lat_g = lat; ready_mode = mode;
    build_exp();
    start_req = 1;
    tick();
    tick();
    chk("start_req", {src_req, busy}, 2'b11);
  endtask

  task automatic finish_stream(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done", done, 1);
    chk("all_beats", exp_q.size(), 0);
    chk("reader_idle", outst, 0);
    chk("busy_off", busy, 0);
  endtask

  initial begin
    state_enable = 0; start = 0; abort = 0;
    src_valid = 0; src_eof = 0; src_char = '0; out_ready = 0;
    ready_mode = 0; lat_g = 1;
    clear_bench();
    repeat (2) @(posedge clock);
    #1 check_rst("rst_init");
    @(negedge clock); #2 state_enable = 1;

    // "ab\nc", fast reader, always ready
    file_q = '{8'h61, 8'h62, 8'h0A, 8'h63};
    start_stream(1, 0);
    finish_stream(200);
    repeat (3) tick();
    chk("done_sticky", {done, out_valid}, 2'b10);

    // back-pressure for 20 cycles on a 10-char file
    do_reset();
    gen_file(10);
    start_stream(1, 2);
    repeat (20) tick();
    chk("fill4", held_now, DEPTH);
    ready_mode = 0;
    finish_stream(300);

    // slow reader, random back-pressure
    do_reset();
    gen_file(12);
    start_stream(3, 1);
    finish_stream(500);

    // empty file
    do_reset();
    file_q.delete();
    start_stream(1, 0);
    finish_stream(50);

    // abort with 3 buffered and one request in flight
    do_reset();
    gen_file(10);
    start_stream(3, 2);
    begin
      int g = 0;
      while (!(held_now == 3 && outst) && g < 100) begin
        tick();
        g++;
      end
    end
    chk("abort_setup", {held_now[7:0], 7'b0, outst}, {8'd3, 8'd1});
    abort_req = 1;
    tick();
    ready_mode = 0;
    finish_stream(100);

    // reset mid-stream, then a clean restart
    do_reset();
    gen_file(30);
    start_stream(1, 1);
    repeat (15) tick();
    do_reset();
    gen_file(8);
    start_stream(2, 1);
    finish_stream(300);

    // random files
    for (int k = 0; k < 4; k++) begin
      do_reset();
      gen_file($urandom_range(1, 25));
      start_stream($urandom_range(1, 3), 1);
      finish_stream(800);
    end

    // column saturation on a very long line
    do_reset();
    file_q.delete();
    for (int i = 0; i < 4100; i++) file_q.push_back(8'h78);
    file_q.push_back(8'h0A);
    file_q.push_back(8'h79);
    start_stream(1, 0);
    finish_stream(9000);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/html_stream_controller.md
# html_stream_controller

Sequencer between the HTML file reader and the tokenizer. Pulls characters from the reader one request at a time and buffers them in a small FIFO. Presents them downstream over a valid/ready handshake with line/column tags. On end of file it emits a single NUL terminator beat. It is the only block that drives the reader, and it decouples reader latency from tokenizer back-pressure.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `LINE_W`, 16: line counter width.
- `COL_W`, 12: column counter width.

Ports:
- `clock` in 1: sole clock, rising edge.
- `state_enable` in 1: asynchronous, active-low reset (low = reset; high = run).
- `start` in 1: one-cycle pulse that begins streaming; ignored outside IDLE.
- `abort` in 1: stop streaming and discard buffered characters.
- `src_req` out 1: one-cycle request to the reader for the next character.
- `src_valid` in 1: reader response carrying a character; comes 1 or more cycles after `src_req`.
- `src_eof` in 1: reader response meaning no character remains; mutually exclusive with `src_valid`.
- `src_char` in `CHAR_BITES`: character that accompanies `src_valid`.
- `out_valid` out 1: downstream beat valid.
- `out_ready` in 1: downstream accepts the beat.
- `out_char` out `CHAR_BITES`: character.
- `out_last` out 1: marks the terminator beat (`out_char`=0x00).
- `out_line` out `LINE_W`: line of `out_char`, 1-based.
- `out_col` out `COL_W`: column of `out_char`, 1-based.
- `busy` out 1: state is not IDLE or DONE.
- `done` out 1: state is DONE.

## Operation
- States:
  - IDLE: `start` → FETCH.
  - FETCH: `src_eof` → DRAIN; `abort` → FLUSH.
  - DRAIN: FIFO empty and terminator accepted → DONE; `abort` → FLUSH.
  - FLUSH: no request outstanding → DONE.
  - DONE: stays until reset.
- At most one request is outstanding. `inflight` is set by `src_req` and cleared by `src_valid` or `src_eof`.
- `src_req` is issued in FETCH when `!inflight` and `count + 0 < DEPTH`, with `abort` low.
- `src_valid` pushes `src_char`. The slot is reserved when the request is issued, so a push never overflows.
- A pop occurs on `out_valid & out_ready`. Push and pop may happen in the same cycle; `count` is then unchanged.
- Pointers wrap modulo `DEPTH`.
- Terminator: in DRAIN with FIFO empty, `out_valid`=1, `out_last`=1, `out_char`=0x00, with line/col of the position following the last character.
- Line/col start at 1/1. On each accepted non-terminator beat:
  - if `out_char`=0x0A: line+1 (saturating) and col←1;
  - else col+1 (saturating at all-ones).
- Abort:
  - FIFO is cleared the same edge.
  - A response that arrives in FLUSH is discarded.
  - No terminator beat is emitted.
  - `abort` outside FETCH/DRAIN is ignored.
- A `src_valid`/`src_eof` with no outstanding request is ignored.

## Timing
- Reset values: `src_req`=0, `out_valid`=0, `out_last`=0, `out_char`=0, `out_line`=1, `out_col`=1, `busy`=0, `done`=0. FIFO is empty and `inflight`=0.
- Reset is honoured mid-stream: all state returns to the reset values asynchronously.
- `start` sampled at edge N → FETCH at N; `src_req` is high at N+1.
- `src_valid` sampled at edge M → `out_valid` high after edge M (visible in cycle M+1). This is 1-cycle fill latency.
- `out_valid`, `out_char`, `out_last`, `out_line`, `out_col` are driven from registers and FIFO storage only, never combinationally from `out_ready`.
- Once `out_valid` is asserted, the beat holds stable until accepted, except on abort or reset.
- Sustained throughput is 1 char every 2 cycles with a 1-cycle reader. This limit comes from the single outstanding request.
- `src_eof` sampled at edge E with FIFO empty → terminator beat valid in cycle E+1.

## Structure
- Shared package `html_pkg`:
  - `CHAR_BITES` width constant (8);
  - `CHAR_NUL`=0x00 and `CHAR_LF`=0x0A;
  - state encoding IDLE/FETCH/DRAIN/FLUSH/DONE.
- Sub-module `char_fifo`: parameterised `DEPTH` × `CHAR_BITES` sync FIFO with push/pop/clear, count, async active-low reset.
- The FSM, request credit logic and line/col counters stay in the top level.

## Test plan
- Stream "ab\nc" with a 1-cycle reader and `out_ready`=1 → beats a(1,1), b(1,2), 0x0A(1,3), c(2,1), then NUL `out_last`(2,2); `done`=1 afterwards.
- Hold `out_ready`=0 for 20 cycles during a 10-char file → FIFO fills to 4, `src_req` stays low, no loss or duplication after release.
- Reader with 3-cycle latency → at most one `src_req` pulse between responses; order is preserved.
- Empty file (`src_eof` on the first response) → single NUL beat at line 1, col 1.
- `abort` with 3 chars buffered and 1 request in flight → `out_valid`=0 the next cycle; the late response is dropped; DONE; no terminator beat.
- Reset pulse mid-stream, then `start` → all outputs back at reset values, and streaming restarts cleanly at line 1, col 1.
